// File: rtl/fdiv_issue_ctrl.sv
// Issue controller for a multi-cycle single-precision divider: accepts one request,
// sequences launch/wait/drain, returns the result with its tag and accumulates fflags.
package fdiv_issue_pkg;
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_DIVBYZERO = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_INVALID   = 3'd3,
    ERR_UNDERFLOW = 3'd4
  } o_err_t;
endpackage

module fdiv_issue_ctrl
  import fdiv_issue_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_rm,
  input  logic [4:0]  req_tag,
  input  logic [2:0]  frm,
  input  logic        flags_clr,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [1:0]  div_rm,
  output logic        div_fdiv,
  output logic        div_ena,
  input  logic        div_busy,
  input  logic        div_stall,
  input  logic [31:0] div_s,
  input  o_err_t      div_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output o_err_t      rsp_err,
  output logic [4:0]  fflags,
  output logic        pipe_stall
);

  localparam int unsigned   DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [31:0]   QNAN       = 32'h7fc0_0000;
  localparam logic [5:0]    WAIT_LAST  = 6'(TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN, S_DONE} state_t;

  // Returns {legal, divider mode}; RMM falls back to nearest-even.
  function automatic logic [2:0] decode_rm(input logic [2:0] rm);
    case (rm)
      3'b000:  decode_rm = 3'b1_00;
      3'b001:  decode_rm = 3'b1_11;
      3'b010:  decode_rm = 3'b1_01;
      3'b011:  decode_rm = 3'b1_10;
      3'b100:  decode_rm = 3'b1_00;
      default: decode_rm = 3'b0_00;
    endcase
  endfunction

  function automatic logic [4:0] err_flags(input o_err_t e);
    case (e)
      ERR_INVALID:   err_flags = 5'b10000;
      ERR_DIVBYZERO: err_flags = 5'b01000;
      ERR_OVERFLOW:  err_flags = 5'b00100;
      ERR_UNDERFLOW: err_flags = 5'b00010;
      default:       err_flags = 5'b00000;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   div_a_q, div_a_d, div_b_q, div_b_d, rsp_data_q, rsp_data_d;
  logic [1:0]    div_rm_q, div_rm_d;
  logic [4:0]    rsp_tag_q, rsp_tag_d, fflags_q, fflags_d, new_flags_s;
  o_err_t        rsp_err_q, rsp_err_d;
  logic [5:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [2:0]    rm_eff_s, rm_dec_s;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
      div_rm_q    <= 2'd0;
      rsp_data_q  <= 32'd0;
      rsp_tag_q   <= 5'd0;
      rsp_err_q   <= ERR_NONE;
      fflags_q    <= 5'd0;
      wait_cnt_q  <= 6'd0;
      drain_cnt_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_rm_q    <= div_rm_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      fflags_q    <= fflags_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state, operand latching, result capture and flag accumulation.
  always_comb begin
    state_d     = state_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_rm_d    = div_rm_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    new_flags_s = 5'd0;
    rm_eff_s    = (req_rm == 3'b111) ? frm : req_rm;
    rm_dec_s    = decode_rm(rm_eff_s);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          div_a_d   = req_a;
          div_b_d   = req_b;
          div_rm_d  = rm_dec_s[1:0];
          rsp_tag_d = req_tag;
          if (rm_dec_s[2]) begin
            state_d = S_LAUNCH;
          end else begin
            state_d    = S_DONE;
            rsp_data_d = QNAN;
            rsp_err_d  = ERR_INVALID;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d    = S_WAIT;
        wait_cnt_d = 6'd0;
      end
      S_WAIT: begin
        // The first WAIT cycle never completes, even if busy has not yet risen.
        if (!div_busy && (wait_cnt_q != 6'd0)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_DONE;
          rsp_data_d = QNAN;
          rsp_err_d  = ERR_INVALID;
        end else begin
          wait_cnt_d = wait_cnt_q + 6'd1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == {DW{1'b0}}) begin
          state_d    = S_DONE;
          rsp_data_d = div_s;
          rsp_err_d  = div_err;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          new_flags_s = err_flags(rsp_err_q);
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    fflags_d = (flags_clr ? 5'd0 : fflags_q) | new_flags_s;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign div_fdiv   = (state_q == S_LAUNCH);
  assign div_ena    = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign rsp_valid  = (state_q == S_DONE);
  assign pipe_stall = div_ena || div_stall;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_rm     = div_rm_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign fflags     = fflags_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Randomized bench for fdiv_issue_ctrl with a transaction-level reference model
// and a behavioural divider whose busy time is chosen per request.
module tb_fdiv_issue_ctrl;
  import fdiv_issue_pkg::*;

  localparam int DRAIN_CYC = 3;
  localparam int TIMEOUT   = 63;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_rm, frm;
  logic [4:0]  req_tag;
  logic        flags_clr;
  logic [31:0] div_a, div_b, div_s, rsp_data;
  logic [1:0]  div_rm;
  logic        div_fdiv, div_ena, div_busy, div_stall;
  o_err_t      div_err, rsp_err;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_tag, fflags;
  logic        pipe_stall;

  int total = 0;
  int bad   = 0;
  logic [4:0] model_ff;

  fdiv_issue_ctrl #(.DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_rm(req_rm), .req_tag(req_tag), .frm(frm), .flags_clr(flags_clr),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_fdiv(div_fdiv), .div_ena(div_ena),
    .div_busy(div_busy), .div_stall(div_stall), .div_s(div_s), .div_err(div_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .fflags(fflags), .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference rules: effective rm, legality, divider mode and flag bit per error code.
  function automatic logic [2:0] eff_rm(input logic [2:0] rm, input logic [2:0] f);
    return (rm == 3'd7) ? f : rm;
  endfunction

  function automatic logic legal_rm(input logic [2:0] rm, input logic [2:0] f);
    return eff_rm(rm, f) < 3'd5;
  endfunction

  function automatic logic [1:0] exp_mode(input logic [2:0] rm, input logic [2:0] f);
    logic [1:0] tbl [0:4];
    tbl = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    return tbl[eff_rm(rm, f)];
  endfunction

  function automatic logic [4:0] flag_of(input o_err_t e);
    logic [4:0] tbl [0:4];
    tbl = '{5'h00, 5'h08, 5'h04, 5'h10, 5'h02};
    return tbl[int'(e)];
  endfunction

  task automatic check_reset_vals();
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_div_fdiv", 32'(div_fdiv), 32'd0);
    check_eq("rst_div_ena", 32'(div_ena), 32'd0);
    check_eq("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check_eq("rst_fflags", 32'(fflags), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'(ERR_NONE));
    check_eq("rst_div_a", div_a, 32'd0);
    check_eq("rst_div_b", div_b, 32'd0);
    check_eq("rst_div_rm", 32'(div_rm), 32'd0);
  endtask

  // One request from acceptance through the response handshake; called at a negedge.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input logic [2:0] f, input logic [4:0] tag, input int busy_len,
                         input int hold, input logic clr_hs, input logic [31:0] dres,
                         input o_err_t derr);
    logic ok, to;
    int w, exp_lat, lat, fdivs, busy_left;
    logic [31:0] exp_data;
    o_err_t exp_err;
    ok       = legal_rm(rm, f);
    to       = ok && (busy_len >= TIMEOUT);
    w        = to ? TIMEOUT : ((busy_len + 1 < 2) ? 2 : busy_len + 1);
    exp_lat  = ok ? (1 + w + (to ? 0 : DRAIN_CYC) + 1) : 1;
    exp_data = (ok && !to) ? dres : 32'h7fc0_0000;
    exp_err  = (ok && !to) ? derr : ERR_INVALID;

    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_rm = rm; frm = f; req_tag = tag;
    @(posedge clk); @(negedge clk);
    lat = 1; fdivs = 0; busy_left = 0;
    while (!rsp_valid && lat < 200) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a = $urandom; req_b = $urandom;
      req_rm = 3'($urandom_range(0, 7)); req_tag = 5'($urandom_range(0, 31));
      check_eq("busy_req_ready", 32'(req_ready), 32'd0);
      check_eq("busy_pipe_stall", 32'(pipe_stall), 32'(div_ena));
      if (div_ena && ok) check_eq("div_rm", 32'(div_rm), 32'(exp_mode(rm, f)));
      if (div_fdiv) begin
        fdivs++;
        check_eq("div_a", div_a, a);
        check_eq("div_b", div_b, b);
        div_s = dres; div_err = derr;
        busy_left = busy_len;
        div_busy = (busy_len > 0);
      end else begin
        div_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      if ($urandom_range(0, 15) == 0) begin
        flags_clr = 1'b1; model_ff = 5'd0;
      end else begin
        flags_clr = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    flags_clr = 1'b0; div_busy = 1'b0;
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("fdiv_pulses", 32'(fdivs), ok ? 32'd1 : 32'd0);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_tag", 32'(rsp_tag), 32'(tag));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("done_div_ena", 32'(div_ena), 32'd0);
    check_eq("done_pipe_stall", 32'(pipe_stall), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rsp_data", rsp_data, exp_data);
      check_eq("hold_rsp_tag", 32'(rsp_tag), 32'(tag));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_div_ena", 32'(div_ena), 32'd0);
      check_eq("hold_fflags", 32'(fflags), 32'(model_ff));
    end
    req_valid = 1'b0; rsp_ready = 1'b1; flags_clr = clr_hs;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0; flags_clr = 1'b0;
    model_ff = (clr_hs ? 5'd0 : model_ff) | flag_of(exp_err);
    check_eq("hs_fflags", 32'(fflags), 32'(model_ff));
    check_eq("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] r_rm, r_f;
    int r_len;
    rstn = 1'b0; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0; req_rm = 3'd0;
    req_tag = 5'd0; frm = 3'd0; flags_clr = 1'b0; div_busy = 1'b0; div_stall = 1'b0;
    div_s = 32'd0; div_err = ERR_NONE; rsp_ready = 1'b0; model_ff = 5'd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rstn = 1'b1;
    @(negedge clk);

    // Reset while the divider is busy in WAIT: no response, flags untouched.
    req_valid = 1'b1; req_a = 32'h4120_0000; req_b = 32'h4000_0000; req_rm = 3'd0; req_tag = 5'd9;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; div_busy = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("wait_div_ena", 32'(div_ena), 32'd1);
    check_eq("wait_div_fdiv", 32'(div_fdiv), 32'd0);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1; div_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
    end
    check_eq("post_rst_fflags", 32'(fflags), 32'd0);

    // Divider-stall passthrough while idle.
    div_stall = 1'b1;
    #1 check_eq("div_stall_pass", 32'(pipe_stall), 32'd1);
    @(negedge clk);
    div_stall = 1'b0;

    run_txn(32'h40C0_0000, 32'h4000_0000, 3'd0, 3'd0, 5'd3, 4, 0, 1'b0, 32'h4040_0000, ERR_NONE);
    run_txn(32'h3F80_0000, 32'h0000_0000, 3'd0, 3'd0, 5'd4, 5, 0, 1'b1, 32'h7F80_0000, ERR_DIVBYZERO);
    flags_clr = 1'b1; model_ff = 5'd0;
    @(negedge clk);
    flags_clr = 1'b0;
    run_txn(32'h4000_0000, 32'h3F80_0000, 3'd5, 3'd0, 5'd5, 3, 0, 1'b0, 32'h4000_0000, ERR_NONE);
    run_txn(32'h4110_0000, 32'h4040_0000, 3'd1, 3'd0, 5'd17, 2, 5, 1'b0, 32'h4040_0000, ERR_OVERFLOW);
    run_txn(32'h4110_0000, 32'h4040_0000, 3'd0, 3'd0, 5'd21, 70, 2, 1'b0, 32'h1234_5678, ERR_NONE);
    run_txn(32'h0000_0001, 32'h4F00_0000, 3'd2, 3'd0, 5'd22, TIMEOUT, 0, 1'b0, 32'h0, ERR_UNDERFLOW);
    run_txn(32'h0000_0001, 32'h4F00_0000, 3'd3, 3'd0, 5'd23, TIMEOUT - 1, 0, 1'b0, 32'h1, ERR_UNDERFLOW);
    run_txn(32'h3F80_0000, 32'h4040_0000, 3'd4, 3'd0, 5'd24, 0, 1, 1'b0, 32'h3EAA_AAAB, ERR_NONE);
    run_txn(32'h3F80_0000, 32'h4040_0000, 3'd7, 3'd2, 5'd25, 1, 0, 1'b0, 32'h3EAA_AAAA, ERR_NONE);
    run_txn(32'h3F80_0000, 32'h4040_0000, 3'd7, 3'd7, 5'd26, 1, 0, 1'b1, 32'h3EAA_AAAA, ERR_NONE);
    run_txn(32'h3F80_0000, 32'h4040_0000, 3'd6, 3'd0, 5'd27, 1, 0, 1'b0, 32'h3EAA_AAAA, ERR_NONE);

    for (int n = 0; n < 40; n++) begin
      r_rm  = 3'($urandom_range(0, 7));
      r_f   = 3'($urandom_range(0, 7));
      r_len = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 10);
      run_txn($urandom, $urandom, r_rm, r_f, 5'($urandom_range(0, 31)), r_len,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
              o_err_t'(3'($urandom_range(0, 4))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
